pc_sequencer: RTL and testbench

- Program-counter sequencer for the processor core. It owns the PC register, the registered zero flag and a LIFO return stack.
- Each enabled cycle it decodes the jump and subroutine opcode groups and selects the next PC: sequential, target, or popped return address.
- Sits between instruction memory (it drives the PC address) and the decode/ALU stage. From that stage it takes `opcode`, the jump target field, `wez` and the ALU zero output.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 114 +++++++++++
 tb/tb_pc_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus between the decode/ALU stage (master) and the program-counter sequencer (slave).
// Carries the advance enable, the instruction fields and the sequencer's status outputs.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic            en;
  logic [5:0]      opcode;
  logic [PC_W-1:0] target;
  logic            wez;
  logic            alu_zero;
  logic [PC_W-1:0] pc;
  logic            z_flag;
  logic            taken;
  logic [SP_W-1:0] sp;
  logic            stk_ovf;
  logic            stk_unf;

  modport master (
    output en, opcode, target, wez, alu_zero,
    input  pc, z_flag, taken, sp, stk_ovf, stk_unf
  );

  modport slave (
    input  en, opcode, target, wez, alu_zero,
    output pc, z_flag, taken, sp, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, registered zero flag and LIFO return stack.
// Define STACK_TRAP_EN to redirect erroneous CALL/RET to TRAP_VEC instead of falling through.
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 4,
  parameter int TRAP_VEC = 0
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.slave     bus
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);
`ifdef STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [5:0] {
    OP_CALL = 6'b111000,
    OP_RET  = 6'b111001,
    OP_J    = 6'b111100,
    OP_JZ   = 6'b111101,
    OP_JNZ  = 6'b111110
  } op_e;

  logic [PC_W-1:0]  stack [DEPTH];
  logic [PC_W-1:0]  pc_q, pc_inc, next_pc;
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic             z_q, ovf_q, unf_q;
  logic             taken_c, push, pop, ovf_set, unf_set;

  assign pc_inc   = pc_q + PC_W'(1);
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  // Next-PC select; branches see the flag as it stood before this edge.
  always_comb begin
    next_pc = pc_inc;
    taken_c = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (bus.opcode)
      OP_J: begin
        next_pc = bus.target;
        taken_c = 1'b1;
      end
      OP_JZ: if (z_q) begin
        next_pc = bus.target;
        taken_c = 1'b1;
      end
      OP_JNZ: if (!z_q) begin
        next_pc = bus.target;
        taken_c = 1'b1;
      end
      OP_CALL: if (sp_q < SP_FULL) begin
        next_pc = bus.target;
        taken_c = 1'b1;
        push    = 1'b1;
      end else begin
        next_pc = TRAP_EN ? TRAP_PC : pc_inc;
        taken_c = TRAP_EN;
        ovf_set = 1'b1;
      end
      OP_RET: if (sp_q != '0) begin
        next_pc = stack[pop_idx];
        taken_c = 1'b1;
        pop     = 1'b1;
      end else begin
        next_pc = TRAP_EN ? TRAP_PC : pc_inc;
        taken_c = TRAP_EN;
        unf_set = 1'b1;
      end
      default: next_pc = pc_inc;
    endcase
    if (!bus.en) taken_c = 1'b0;
  end

  // Architectural state; everything holds while en is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= '0;
      z_q   <= 1'b0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (bus.en) begin
      pc_q <= next_pc;
      if (bus.wez) z_q <= bus.alu_zero;
      if (push)     sp_q <= sp_q + SP_W'(1);
      else if (pop) sp_q <= sp_q - SP_W'(1);
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Stack storage is deliberately not cleared by reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    if (reset && bus.en && push) stack[push_idx] <= pc_inc;
  end

  assign bus.pc      = pc_q;
  assign bus.z_flag  = z_q;
  assign bus.taken   = taken_c;
  assign bus.sp      = sp_q;
  assign bus.stk_ovf = ovf_q;
  assign bus.stk_unf = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized opcode streams
// compared against a queue-based reference model of the sequencer.
module tb_pc_sequencer;
  localparam int PC_W     = 10;
  localparam int DEPTH    = 4;
  localparam int TRAP_VEC = 0;
  localparam int PC_MOD   = 1 << PC_W;

  localparam logic [5:0] OP_NOP  = 6'b000100;
  localparam logic [5:0] OP_CALL = 6'b111000;
  localparam logic [5:0] OP_RET  = 6'b111001;
  localparam logic [5:0] OP_J    = 6'b111100;
  localparam logic [5:0] OP_JZ   = 6'b111101;
  localparam logic [5:0] OP_JNZ  = 6'b111110;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   m_pc;
  bit   m_z, m_ovf, m_unf;
  int   m_stack[$];

  pc_sequencer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .TRAP_VEC(TRAP_VEC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".pc"},  32'(bus.pc),      32'(m_pc));
    check_output({tag, ".z"},   32'(bus.z_flag),  32'(m_z));
    check_output({tag, ".sp"},  32'(bus.sp),      32'(m_stack.size()));
    check_output({tag, ".ovf"}, 32'(bus.stk_ovf), 32'(m_ovf));
    check_output({tag, ".unf"}, 32'(bus.stk_unf), 32'(m_unf));
  endtask

  // One cycle: drive at the falling edge, check taken, then check state after the rising edge.
  task automatic apply_stimulus(input string tag, input bit en, input logic [5:0] op,
                                input int tgt, input bit w, input bit az);
    int nxt;
    int inc;
    bit tk;
    bit nz;
    @(negedge clk);
    bus.en       = en;
    bus.opcode   = op;
    bus.target   = PC_W'(tgt);
    bus.wez      = w;
    bus.alu_zero = az;
    inc = (m_pc + 1) % PC_MOD;
    nxt = inc;
    tk  = 1'b0;
    nz  = m_z;
    if (en) begin
      if (op == OP_J) begin
        nxt = tgt; tk = 1'b1;
      end else if (op == OP_JZ && m_z) begin
        nxt = tgt; tk = 1'b1;
      end else if (op == OP_JNZ && !m_z) begin
        nxt = tgt; tk = 1'b1;
      end else if (op == OP_CALL) begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(inc);
          nxt = tgt; tk = 1'b1;
        end else begin
          m_ovf = 1'b1;
`ifdef STACK_TRAP_EN
          nxt = TRAP_VEC; tk = 1'b1;
`endif
        end
      end else if (op == OP_RET) begin
        if (m_stack.size() > 0) begin
          nxt = m_stack.pop_back();
          tk = 1'b1;
        end else begin
          m_unf = 1'b1;
`ifdef STACK_TRAP_EN
          nxt = TRAP_VEC; tk = 1'b1;
`endif
        end
      end
      if (w) nz = az;
    end else begin
      nxt = m_pc;
    end
    #1;
    check_output({tag, ".taken"}, 32'(bus.taken), 32'(tk));
    @(posedge clk);
    #1;
    m_pc = nxt;
    m_z  = nz;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.en = 1'b0;
    #2 reset = 1'b0;
    #1;
    m_pc = 0; m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_stack.delete();
    check_state(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] rop;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.opcode = OP_NOP;
    bus.target = '0;
    bus.wez = 1'b0;
    bus.alu_zero = 1'b0;
    m_pc = 0; m_z = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    check_state("por");
    @(negedge clk);
    reset = 1'b1;

    // Count up to 5, reset mid-run, then count 1,2.
    for (int i = 0; i < 5; i++) apply_stimulus("nop_run", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    check_output("pc_before_reset", 32'(bus.pc), 32'h5);
    do_reset("mid_reset");
    check_output("pc_after_reset", 32'(bus.pc), 32'h0);
    apply_stimulus("post_rst1", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    apply_stimulus("post_rst2", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    check_output("count_two", 32'(bus.pc), 32'h2);

    // Zero flag and conditional branches.
    apply_stimulus("to_pc3", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    apply_stimulus("set_z1", 1'b1, OP_NOP, 0, 1'b1, 1'b1);
    apply_stimulus("jz_taken", 1'b1, OP_JZ, 'h40, 1'b0, 1'b0);
    check_output("jz_target", 32'(bus.pc), 32'h40);
    apply_stimulus("set_z0", 1'b1, OP_NOP, 0, 1'b1, 1'b0);
    apply_stimulus("jz_not", 1'b1, OP_JZ, 'h80, 1'b0, 1'b0);
    check_output("jz_fall", 32'(bus.pc), 32'h42);
    apply_stimulus("jz_same_cyc", 1'b1, OP_JZ, 'h90, 1'b1, 1'b1);
    check_output("jz_old_flag", 32'(bus.pc), 32'h43);
    apply_stimulus("jnz_z1", 1'b1, OP_JNZ, 'h90, 1'b1, 1'b0);
    apply_stimulus("jnz_z0", 1'b1, OP_JNZ, 'h91, 1'b0, 1'b0);
    check_output("jnz_target", 32'(bus.pc), 32'h91);

    // Nested calls and returns.
    do_reset("nest_reset");
    apply_stimulus("nest_nop1", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    apply_stimulus("nest_nop2", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    apply_stimulus("call1", 1'b1, OP_CALL, 'h10, 1'b0, 1'b0);
    check_output("call1_pc", 32'(bus.pc), 32'h10);
    apply_stimulus("call2", 1'b1, OP_CALL, 'h20, 1'b0, 1'b0);
    check_output("call2_pc", 32'(bus.pc), 32'h20);
    apply_stimulus("ret1", 1'b1, OP_RET, 0, 1'b0, 1'b0);
    check_output("ret1_pc", 32'(bus.pc), 32'h11);
    apply_stimulus("ret2", 1'b1, OP_RET, 0, 1'b0, 1'b0);
    check_output("ret2_pc", 32'(bus.pc), 32'h03);
    check_output("ret2_sp", 32'(bus.sp), 32'h0);

    // Stack overflow on the fifth nested call.
    do_reset("ovf_reset");
    for (int i = 0; i < DEPTH + 1; i++) apply_stimulus("ovf_call", 1'b1, OP_CALL, 'h100 + 16 * i, 1'b0, 1'b0);
    check_output("ovf_sp", 32'(bus.sp), 32'(DEPTH));
    check_output("ovf_flag", 32'(bus.stk_ovf), 32'h1);
    for (int i = 0; i < DEPTH; i++) apply_stimulus("ovf_unwind", 1'b1, OP_RET, 0, 1'b0, 1'b0);

    // Underflow stickiness and PC wrap.
    do_reset("unf_reset");
    apply_stimulus("unf_ret", 1'b1, OP_RET, 0, 1'b0, 1'b0);
    check_output("unf_flag", 32'(bus.stk_unf), 32'h1);
    for (int i = 0; i < 10; i++) apply_stimulus("unf_sticky", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    check_output("unf_still", 32'(bus.stk_unf), 32'h1);
    apply_stimulus("to_max", 1'b1, OP_J, 'h3FF, 1'b0, 1'b0);
    apply_stimulus("wrap", 1'b1, OP_NOP, 0, 1'b0, 1'b0);
    check_output("wrap_pc", 32'(bus.pc), 32'h0);

    // Stall while a jump and flag write are presented.
    apply_stimulus("pre_stall", 1'b1, OP_CALL, 'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus("stall", 1'b0, OP_J, 'h200, 1'b1, 1'b1);
    check_output("stall_pc", 32'(bus.pc), 32'h55);
    apply_stimulus("resume", 1'b1, OP_J, 'h200, 1'b1, 1'b1);
    check_output("resume_pc", 32'(bus.pc), 32'h200);

    // Randomized opcode stream, mostly from the control-flow group.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset("rnd_reset");
      if ($urandom_range(0, 9) < 8) rop = {3'b111, 3'($urandom_range(0, 7))};
      else rop = 6'($urandom_range(0, 55));
      apply_stimulus("rnd", ($urandom_range(0, 7) != 0), rop, int'($urandom_range(0, PC_MOD - 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
